irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//  Interrupt front-end directly upstream of the CP0 register file. Synchronises the
//  async external IRQ lines, applies Status IM/IE masking, selects one winner by fixed
//  priority, drives CP0's exception/EPC/ext_int inputs, and blocks nesting until ERET.
// PARAMETERS
//  NUM_IRQ      6   external IRQ lines; fixed at 6 to match CP0 Cause[15:10]
//  SYNC_STAGES  2   synchroniser flops per line; legal values are 2 or 3
// PORTS
//  clk          in   1   core clock
//  rst          in   1   asynchronous, active-high reset
//  irq_in       in   6   raw asynchronous interrupt lines, active-high
//  status_im    in   6   CP0 Status[15:10] interrupt mask; 1 = enabled
//  status_ie    in   1   CP0 Status[0] global interrupt enable
//  pc_i         in   32  PC of the next instruction to be interrupted
//  pc_valid_i   in   1   pipeline is at a boundary where an interrupt may be taken
//  eret_i       in   1   1-cycle pulse when ERET retires
//  exception_o  out  1   1-cycle pulse to CP0 exception_i
//  epc_o        out  32  PC captured at take time; feeds CP0 epc_i
//  ext_int_o    out  6   masked pending snapshot at take time; feeds CP0 ext_int
//  irq_id_o     out  3   index of the winning line, 0..5
//  in_service_o out  1   high from the take cycle until ERET is accepted
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; synchroniser, edge and pending flops all 0.
//  - Sync: irq_s = last flop of a SYNC_STAGES chain per bit; no logic sits between flops.
//  - Request vector: req = pend & status_im, where pend is defined under CONFIGURATION.
//  - Priority: the lowest set index of req wins. Bit 0 has the highest priority.
//  - FSM states: IDLE and SERVICE.
//    IDLE -> SERVICE when (req != 0) && status_ie && pc_valid_i.
//      On the next edge, the registered outputs take these values:
//      exception_o=1 for exactly one cycle, epc_o=pc_i, ext_int_o=req,
//      irq_id_o=winner, in_service_o=1.
//    SERVICE -> IDLE on eret_i; in_service_o falls on that same edge.
//    SERVICE holds while eret_i=0. New requests stay pending and are not taken (no nesting).
//  - eret_i is ignored in IDLE.
//  - epc_o, ext_int_o and irq_id_o hold their values until the next take.
//  - Simultaneous eret_i and a pending req in SERVICE: return to IDLE first.
//    The earliest re-take is one cycle later, so exception_o pulses are never adjacent.
//  - Latency, level mode: irq_in is sampled high at edge k; irq_s=1 after edge k+SYNC_STAGES-1;
//    exception_o=1 in the cycle after edge k+SYNC_STAGES, provided mask, IE and pc_valid_i allow it.
//  - status_im, status_ie or irq_in changing during SERVICE: no effect on latched outputs.
//  - status_ie=0 or pc_valid_i=0 in IDLE: no take. Pending bits are kept, never lost.
//  - rst asserted mid-SERVICE: back to IDLE, pending cleared, and no exception_o glitch.
//  - Widths: epc_o is a straight 32-bit copy with no alignment check. irq_id_o is 3 bits, range 0..5.
// CONFIGURATION
//  IRQ_EDGE_EN undefined (level mode):
//    - pend = irq_s; there is no pending storage.
//    - The ISR must deassert the device line before ERET, otherwise the IRQ is re-taken.
//  IRQ_EDGE_EN defined (edge mode):
//    - A rising edge of irq_s (irq_s & ~irq_s_d) sets pend[i] on the next clock.
//    - pend[winner] clears on the take edge; the other pend bits are kept.
//    - If a set and a clear of the same bit land on the same edge, the set wins.
//    - Adds 1 cycle of latency versus level mode.
//    - A line held high produces exactly one interrupt.
// TESTING
//  1 Reset: rst=1 with irq_in=6'h3F -> all outputs 0; after release with IE=0, no exception_o.
//  2 Single IRQ (level mode, SYNC=2): IM=6'h3F, IE=1, pc_valid=1, pc_i=32'h0000_1040,
//    irq_in[3] set at edge 0 ->
//    - exception_o pulses 1 cycle after edge 2.
//    - epc_o=32'h1040, ext_int_o=6'h08, irq_id_o=3, in_service_o=1.
//  3 Priority and mask: irq_in=6'h2C, IM=6'h28 ->
//    - winner is 3, ext_int_o=6'h28.
//    - bit 2 is never taken while masked.
//  4 No nesting: in SERVICE, raise irq_in[0] ->
//    - no exception_o until eret_i.
//    - eret at cycle t gives a re-take pulse at t+2 with irq_id_o=0.
//  5 Gating: req present with pc_valid_i=0 for 5 cycles ->
//    - no take during those 5 cycles.
//    - take 1 cycle after pc_valid_i rises, with epc_o = pc_i of that cycle.
//  6 IRQ_EDGE_EN: hold irq_in[1] high across two ERETs -> exactly one exception_o.
//    A 1-cycle-wide pulse (on a synced line) arriving during SERVICE is taken after ERET.

Source files
------------

// File: rtl/irq_ctrl.sv
// Interrupt front-end ahead of CP0: sync, IM/IE mask, fixed-priority select, no nesting until ERET.
// Optional macro IRQ_EDGE_EN: latch rising edges into pending bits instead of using raw levels.
module irq_ctrl #(
  parameter int NUM_IRQ     = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic [NUM_IRQ-1:0]  status_im,
  input  logic                status_ie,
  input  logic [31:0]         pc_i,
  input  logic                pc_valid_i,
  input  logic                eret_i,
  output logic                exception_o,
  output logic [31:0]         epc_o,
  output logic [NUM_IRQ-1:0]  ext_int_o,
  output logic [2:0]          irq_id_o,
  output logic                in_service_o
);

  localparam logic IDLE    = 1'b0;
  localparam logic SERVICE = 1'b1;

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
  logic [NUM_IRQ-1:0] irq_s, pend, req;
  logic [2:0]         winner;
  logic               state;
  logic               take;

  // Plain flop chain; nothing combinational between stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
  end

  assign irq_s = sync_q[SYNC_STAGES-1];

`ifdef IRQ_EDGE_EN
  logic [NUM_IRQ-1:0] irq_s_d, rise, clr;

  assign rise = irq_s & ~irq_s_d;
  assign clr  = take ? (NUM_IRQ'(1) << winner) : '0;

  // Set has priority over the take-edge clear of the same bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_s_d <= '0;
      pend    <= '0;
    end else begin
      irq_s_d <= irq_s;
      pend    <= (pend & ~clr) | rise;
    end
  end
`else
  assign pend = irq_s;
`endif

  assign req = pend & status_im;

  always_comb begin
    winner = 3'd0;
    for (int i = NUM_IRQ-1; i >= 0; i--)
      if (req[i]) winner = 3'(i);
  end

  assign take = (state == IDLE) && (|req) && status_ie && pc_valid_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      exception_o  <= 1'b0;
      epc_o        <= '0;
      ext_int_o    <= '0;
      irq_id_o     <= '0;
      in_service_o <= 1'b0;
    end else begin
      exception_o <= 1'b0;
      if (take) begin
        state        <= SERVICE;
        exception_o  <= 1'b1;
        epc_o        <= pc_i;
        ext_int_o    <= req;
        irq_id_o     <= winner;
        in_service_o <= 1'b1;
      end else if (state == SERVICE && eret_i) begin
        // Leaving SERVICE blocks a take on this edge, so pulses never abut.
        state        <= IDLE;
        in_service_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl; edge-mode vectors are used when IRQ_EDGE_EN is defined.
module tb_irq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  irq_in = '0;
  logic [5:0]  status_im = '0;
  logic        status_ie = 1'b0;
  logic [31:0] pc_i = '0;
  logic        pc_valid_i = 1'b0;
  logic        eret_i = 1'b0;
  logic        exception_o;
  logic [31:0] epc_o;
  logic [5:0]  ext_int_o;
  logic [2:0]  irq_id_o;
  logic        in_service_o;

  int n_vec = 0;
  int n_err = 0;

  irq_ctrl #(.NUM_IRQ(6), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .status_im(status_im),
    .status_ie(status_ie), .pc_i(pc_i), .pc_valid_i(pc_valid_i), .eret_i(eret_i),
    .exception_o(exception_o), .epc_o(epc_o), .ext_int_o(ext_int_o),
    .irq_id_o(irq_id_o), .in_service_o(in_service_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic eret_pulse();
    eret_i = 1'b1;
    step();
    eret_i = 1'b0;
  endtask

  // Drop lines, let the synchroniser drain, then retire the ISR.
  task automatic finish_isr();
    irq_in = '0;
    step(3);
    eret_pulse();
    chk("isr_done_ins", 32'(in_service_o), 0);
  endtask

  task automatic no_exc(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk(tag, 32'(exception_o), 0);
    end
  endtask

  initial begin
    // Reset with every line asserted
    irq_in = 6'h3F; status_im = 6'h3F; pc_valid_i = 1'b1;
    step(2);
    chk("rst_exc", 32'(exception_o), 0);
    chk("rst_epc", epc_o, 0);
    chk("rst_ext", 32'(ext_int_o), 0);
    chk("rst_id", 32'(irq_id_o), 0);
    chk("rst_ins", 32'(in_service_o), 0);
    rst = 1'b0;
    no_exc("ie0_exc", 5);
    chk("ie0_ins", 32'(in_service_o), 0);
    irq_in = '0;
    step(3);
    status_ie = 1'b1;
    no_exc("quiet_exc", 2);

`ifdef IRQ_EDGE_EN
    // Held line: one take, survives two ERETs without re-taking
    irq_in = 6'h02; pc_i = 32'h0000_0300;
    no_exc("edge_lat", 3);
    step();
    chk("edge_exc", 32'(exception_o), 1);
    chk("edge_id", 32'(irq_id_o), 1);
    chk("edge_epc", epc_o, 32'h0000_0300);
    // Single-cycle pulse on line 4 while in service
    irq_in = 6'h12;
    step();
    irq_in = 6'h02;
    no_exc("edge_svc", 6);
    eret_pulse();
    chk("edge_eret1", 32'(exception_o), 0);
    step();
    chk("edge_pulse_exc", 32'(exception_o), 1);
    chk("edge_pulse_id", 32'(irq_id_o), 4);
    chk("edge_pulse_ext", 32'(ext_int_o), 32'h10);
    eret_pulse();
    no_exc("edge_held_once", 6);
    chk("edge_idle_ins", 32'(in_service_o), 0);
`else
    // Single line 3, SYNC_STAGES=2: pulse after edge 2
    pc_i = 32'h0000_1040;
    irq_in = 6'h08;
    step();
    chk("t2_e0", 32'(exception_o), 0);
    step();
    chk("t2_e1", 32'(exception_o), 0);
    step();
    chk("t2_exc", 32'(exception_o), 1);
    chk("t2_epc", epc_o, 32'h0000_1040);
    chk("t2_ext", 32'(ext_int_o), 32'h08);
    chk("t2_id", 32'(irq_id_o), 3);
    chk("t2_ins", 32'(in_service_o), 1);
    step();
    chk("t2_one_cycle", 32'(exception_o), 0);
    // Mask / IE / PC churn during service leaves latched outputs alone
    status_im = '0; status_ie = 1'b0; pc_i = 32'hDEAD_BEEF;
    step(2);
    chk("t2_hold_epc", epc_o, 32'h0000_1040);
    chk("t2_hold_ext", 32'(ext_int_o), 32'h08);
    chk("t2_hold_ins", 32'(in_service_o), 1);
    status_im = 6'h3F; status_ie = 1'b1;
    finish_isr();
    no_exc("t2_after", 3);

    // Priority under mask: lines 2,3,5 raised, 2 masked off
    status_im = 6'h28; irq_in = 6'h2C; pc_i = 32'h0000_2000;
    step(3);
    chk("t3_exc", 32'(exception_o), 1);
    chk("t3_id", 32'(irq_id_o), 3);
    chk("t3_ext", 32'(ext_int_o), 32'h28);
    irq_in = 6'h24;
    step(3);
    eret_pulse();
    step();
    chk("t3_next_exc", 32'(exception_o), 1);
    chk("t3_next_id", 32'(irq_id_o), 5);
    irq_in = 6'h04;
    step(3);
    eret_pulse();
    no_exc("t3_masked2", 4);
    status_im = 6'h3F;
    step();
    chk("t3_unmask", 32'(exception_o), 1);
    chk("t3_unmask_id", 32'(irq_id_o), 2);
    finish_isr();

    // No nesting: line 0 raised while servicing line 3
    irq_in = 6'h08;
    step(3);
    chk("t4_exc", 32'(exception_o), 1);
    irq_in = 6'h01;
    no_exc("t4_nonest", 6);
    chk("t4_id_hold", 32'(irq_id_o), 3);
    eret_pulse();
    chk("t4_eret_exc", 32'(exception_o), 0);
    chk("t4_eret_ins", 32'(in_service_o), 0);
    step();
    chk("t4_retake", 32'(exception_o), 1);
    chk("t4_retake_id", 32'(irq_id_o), 0);
    finish_isr();

    // pc_valid gating
    pc_valid_i = 1'b0; irq_in = 6'h04; pc_i = 32'h0000_0111;
    step(3);
    no_exc("t5_gated", 5);
    pc_valid_i = 1'b1; pc_i = 32'h0000_3004;
    step();
    chk("t5_exc", 32'(exception_o), 1);
    chk("t5_epc", epc_o, 32'h0000_3004);
    chk("t5_id", 32'(irq_id_o), 2);
    finish_isr();
    chk("t5_epc_hold", epc_o, 32'h0000_3004);

    // Reset mid-service
    irq_in = 6'h01; pc_i = 32'h0000_4000;
    step(3);
    chk("t6_exc", 32'(exception_o), 1);
    irq_in = '0;
    rst = 1'b1;
    #1;
    chk("t6_rst_exc", 32'(exception_o), 0);
    chk("t6_rst_ins", 32'(in_service_o), 0);
    chk("t6_rst_epc", epc_o, 0);
    step();
    rst = 1'b0;
    no_exc("t6_after", 4);
    chk("t6_after_ins", 32'(in_service_o), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
